// File: rtl/level_progress.sv
// NinjaReflex level-progress controller: counts hits per level, enforces a per-level time budget,
// and steps L1 -> L2 -> L3 -> WIN or falls to LOSE. Optional lives support is built with `define LIVES_EN.
module level_progress #(
  parameter int HITS_PER_LEVEL = 4,
  parameter int LEVEL_TIMEOUT  = 50_000_000,
  parameter int TW             = 26,
  parameter int MAX_LIVES      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic       light1,
  output logic       light2,
  output logic       light3,
  output logic       win,
  output logic       lose,
  output logic [1:0] level,
  output logic [2:0] hit_cnt,
  output logic [2:0] lives
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_WIN  = 3'd4,
    S_LOSE = 3'd5
  } state_t;

  localparam logic [2:0]    HITS_TGT = 3'(HITS_PER_LEVEL);
  localparam logic [TW-1:0] TMAX     = TW'(LEVEL_TIMEOUT - 1);

  // Reject parameter sets the counters cannot represent.
  if (HITS_PER_LEVEL < 1 || HITS_PER_LEVEL > 7 || LEVEL_TIMEOUT < 2 ||
      MAX_LIVES < 1 || MAX_LIVES > 7 || (64'd1 << TW) <= 64'(LEVEL_TIMEOUT)) begin : g_bad_params
    $error("level_progress: illegal parameter combination");
  end

  state_t        state_q, state_d;
  logic [2:0]    lights_q, lights_d;
  logic [2:0]    hit_cnt_q, hit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    level_q, level_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          in_level_s;
  logic          timeout_s;
`ifdef LIVES_EN
  logic [2:0]    lives_q, lives_d;
`endif

  assign in_level_s = (state_q == S_L1) || (state_q == S_L2) || (state_q == S_L3);
  assign timeout_s  = (timer_q == TMAX);

  // Next-state computation: start > timeout > miss > hit.
  always_comb begin
    state_d   = state_q;
    lights_d  = lights_q;
    hit_cnt_d = hit_cnt_q;
    timer_d   = timer_q;
`ifdef LIVES_EN
    lives_d   = lives_q;
`endif
    if (start) begin
      state_d   = S_L1;
      lights_d  = 3'd0;
      hit_cnt_d = 3'd0;
      timer_d   = '0;
`ifdef LIVES_EN
      lives_d   = 3'(MAX_LIVES);
`endif
    end else if (in_level_s) begin
      if (timeout_s) begin
        state_d   = S_LOSE;
        hit_cnt_d = 3'd0;
        timer_d   = '0;
      end else if (miss) begin
`ifdef LIVES_EN
        if (lives_q > 3'd1) begin
          lives_d   = lives_q - 3'd1;
          hit_cnt_d = 3'd0;
          timer_d   = timer_q + TW'(1);
        end else begin
          lives_d   = 3'd0;
          state_d   = S_LOSE;
          hit_cnt_d = 3'd0;
          timer_d   = '0;
        end
`else
        state_d   = S_LOSE;
        hit_cnt_d = 3'd0;
        timer_d   = '0;
`endif
      end else if (hit) begin
        if (hit_cnt_q + 3'd1 == HITS_TGT) begin
          hit_cnt_d = 3'd0;
          timer_d   = '0;
          case (state_q)
            S_L1: begin
              state_d     = S_L2;
              lights_d[0] = 1'b1;
            end
            S_L2: begin
              state_d     = S_L3;
              lights_d[1] = 1'b1;
            end
            S_L3: begin
              state_d     = S_WIN;
              lights_d[2] = 1'b1;
            end
            default: state_d = state_q;
          endcase
        end else begin
          hit_cnt_d = hit_cnt_q + 3'd1;
          timer_d   = timer_q + TW'(1);
        end
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      hit_cnt_d = 3'd0;
      timer_d   = '0;
    end
  end

  // Status outputs decoded from the next state so they register alongside it.
  always_comb begin
    level_d = 2'd0;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    case (state_d)
      S_L1:    level_d = 2'd1;
      S_L2:    level_d = 2'd2;
      S_L3:    level_d = 2'd3;
      S_WIN:   win_d   = 1'b1;
      S_LOSE:  lose_d  = 1'b1;
      default: level_d = 2'd0;
    endcase
  end

  // Game state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lights_q  <= 3'd0;
      hit_cnt_q <= 3'd0;
      timer_q   <= '0;
      level_q   <= 2'd0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lights_q  <= lights_d;
      hit_cnt_q <= hit_cnt_d;
      timer_q   <= timer_d;
      level_q   <= level_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

`ifdef LIVES_EN
  // Remaining-lives counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lives_q <= 3'd0;
    end else begin
      lives_q <= lives_d;
    end
  end

  assign lives = lives_q;
`else
  assign lives = 3'd0;
`endif

  assign light1  = lights_q[0];
  assign light2  = lights_q[1];
  assign light3  = lights_q[2];
  assign win     = win_q;
  assign lose    = lose_q;
  assign level   = level_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_level_progress.sv
// Self-checking bench for level_progress: table-driven game run, hand-written corner sequences
// and randomized pulses checked against a behavioural game model.
module tb_level_progress;

  localparam int HITS = 2;
  localparam int TOUT = 20;
`ifdef LIVES_EN
  localparam logic [2:0] START_LIVES = 3'd3;
`else
  localparam logic [2:0] START_LIVES = 3'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic       light1, light2, light3, win, lose;
  logic [1:0] level;
  logic [2:0] hit_cnt, lives;

  int n_tests = 0;
  int n_fail  = 0;

  level_progress #(.HITS_PER_LEVEL(HITS), .LEVEL_TIMEOUT(TOUT), .TW(5), .MAX_LIVES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .miss(miss),
    .light1(light1), .light2(light2), .light3(light3), .win(win), .lose(lose),
    .level(level), .hit_cnt(hit_cnt), .lives(lives)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1..3 playing level, 4 won, 5 lost.
  int       m_phase, m_hits, m_time, m_lives;
  bit [3:1] m_lit;

  function automatic void model_reset();
    m_phase = 0; m_hits = 0; m_time = 0; m_lives = 0; m_lit = '0;
  endfunction

  function automatic void model_step(input bit s, input bit h, input bit m);
    if (s) begin
      m_phase = 1; m_hits = 0; m_time = 0; m_lit = '0; m_lives = int'(START_LIVES);
    end else if (m_phase >= 1 && m_phase <= 3) begin
      if (m_time == TOUT - 1) begin
        m_phase = 5; m_hits = 0; m_time = 0;
      end else if (m) begin
`ifdef LIVES_EN
        if (m_lives > 1) begin
          m_lives--; m_hits = 0; m_time++;
        end else begin
          m_lives = 0; m_phase = 5; m_hits = 0; m_time = 0;
        end
`else
        m_phase = 5; m_hits = 0; m_time = 0;
`endif
      end else if (h) begin
        if (m_hits + 1 == HITS) begin
          m_lit[m_phase] = 1'b1;
          m_phase = m_phase + 1;
          m_hits = 0; m_time = 0;
        end else begin
          m_hits++; m_time++;
        end
      end else begin
        m_time++;
      end
    end
  endfunction

  function automatic logic [12:0] model_vec();
    logic [1:0] lv;
    lv = (m_phase >= 1 && m_phase <= 3) ? 2'(m_phase) : 2'd0;
    return {m_lit[1], m_lit[2], m_lit[3], m_phase == 4, m_phase == 5, lv, 3'(m_hits), 3'(m_lives)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {light1, light2, light3, win, lose, level, hit_cnt, lives};
  endfunction

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got l123=%b w=%b l=%b lvl=%0d hc=%0d lives=%0d, expected l123=%b w=%b l=%b lvl=%0d hc=%0d lives=%0d",
               nm, act[12:10], act[9], act[8], act[7:6], act[5:3], act[2:0],
               exp[12:10], exp[9], exp[8], exp[7:6], exp[5:3], exp[2:0]);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Drive one cycle of pulses at the falling edge; DUT captures on the next rising edge.
  task automatic apply(input bit s, input bit h, input bit m);
    start = s; hit = h; miss = m;
    model_step(s, h, m);
    @(negedge clk);
    start = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset", dut_vec(), 13'd0);
  endtask

  typedef struct {
    bit         s, h, m;
    logic [2:0] lit;
    logic       w, l;
    logic [1:0] lvl;
    logic [2:0] hc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 0, 0, 3'b000, 0, 0, 2'd1, 3'd0};
    tbl[1]  = '{0, 1, 0, 3'b000, 0, 0, 2'd1, 3'd1};
    tbl[2]  = '{0, 0, 0, 3'b000, 0, 0, 2'd1, 3'd1};
    tbl[3]  = '{0, 1, 0, 3'b100, 0, 0, 2'd2, 3'd0};
    tbl[4]  = '{0, 1, 0, 3'b100, 0, 0, 2'd2, 3'd1};
    tbl[5]  = '{0, 0, 0, 3'b100, 0, 0, 2'd2, 3'd1};
    tbl[6]  = '{0, 1, 0, 3'b110, 0, 0, 2'd3, 3'd0};
    tbl[7]  = '{0, 1, 0, 3'b110, 0, 0, 2'd3, 3'd1};
    tbl[8]  = '{0, 1, 0, 3'b111, 1, 0, 2'd0, 3'd0};
    tbl[9]  = '{0, 1, 0, 3'b111, 1, 0, 2'd0, 3'd0};
    tbl[10] = '{0, 0, 1, 3'b111, 1, 0, 2'd0, 3'd0};
    tbl[11] = '{1, 0, 0, 3'b000, 0, 0, 2'd1, 3'd0};

    model_reset();
    @(negedge clk);
    do_reset();

    // Full game to WIN, ignored pulses in WIN, restart.
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].s, tbl[i].h, tbl[i].m);
      chk($sformatf("table[%0d]", i), dut_vec(),
          {tbl[i].lit, tbl[i].w, tbl[i].l, tbl[i].lvl, tbl[i].hc, START_LIVES});
    end

    // Timeout exactly TOUT cycles after L1 entry.
    do_reset();
    apply(1, 0, 0);
    for (int k = 1; k <= TOUT; k++) begin
      apply(0, k == 1, 0);
      if (k == TOUT - 1) chk_bit("timeout_early", lose, 1'b0);
      if (k == TOUT) begin
        chk_bit("timeout_lose", lose, 1'b1);
        chk_bit("timeout_light1", light1, 1'b0);
      end
    end
    chk("timeout_model", dut_vec(), model_vec());

    // Same-cycle hit and miss in L2.
    apply(1, 0, 0);
    apply(0, 1, 0);
    apply(0, 1, 0);
    apply(0, 1, 0);
    apply(0, 1, 1);
`ifdef LIVES_EN
    chk("hit_miss_L2", dut_vec(), {3'b100, 1'b0, 1'b0, 2'd2, 3'd0, 3'd2});
`else
    chk("hit_miss_L2", dut_vec(), {3'b100, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0});
`endif

`ifdef LIVES_EN
    // Lives countdown in L1.
    apply(1, 0, 0);
    apply(0, 0, 1);
    chk("lives_miss1", dut_vec(), {3'b000, 1'b0, 1'b0, 2'd1, 3'd0, 3'd2});
    apply(0, 1, 0);
    apply(0, 0, 1);
    chk("lives_miss2", dut_vec(), {3'b000, 1'b0, 1'b0, 2'd1, 3'd0, 3'd1});
    apply(0, 0, 1);
    chk("lives_miss3", dut_vec(), {3'b000, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0});
`endif

    // Restart mid-L2; then timer must run a full budget from zero, and timeout beats a hit.
    apply(1, 0, 0);
    apply(0, 1, 0);
    apply(0, 1, 0);
    apply(0, 1, 0);
    apply(1, 0, 0);
    chk("restart_mid_L2", dut_vec(), {3'b000, 1'b0, 1'b0, 2'd1, 3'd0, START_LIVES});
    for (int k = 1; k <= TOUT; k++) begin
      apply(0, (k == 1) || (k == TOUT), 0);
      if (k == TOUT - 1) chk("restart_timer_running", dut_vec(), {3'b000, 1'b0, 1'b0, 2'd1, 3'd1, START_LIVES});
    end
    chk("timeout_beats_hit", dut_vec(), {3'b000, 1'b0, 1'b1, 2'd0, 3'd0, START_LIVES});

    // Asynchronous reset mid-L3.
    apply(1, 0, 0);
    for (int k = 0; k < 5; k++) apply(0, 1, 0);
    chk("pre_async_L3", dut_vec(), model_vec());
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_vec(), 13'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 1, 1);
    chk("idle_ignores_pulses", dut_vec(), 13'd0);

    // Randomized pulses against the model.
    for (int k = 0; k < 3000; k++) begin
      apply(($urandom_range(39) == 0), ($urandom_range(2) == 0), ($urandom_range(11) == 0));
      chk("random", dut_vec(), model_vec());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
